instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
Write-side counterpart of the instruction memory's file-read path. It accepts a framed program image from a host as 16-bit words over a valid/ready handshake: header (length), payload words, then an XOR checksum trailer. Payload words are written sequentially into instruction memory from address 0. It signals fin_file on success and err on a malformed frame. It sits between the host/testbench and instr_mem, replacing the $readmemb-style file load.

Parameters:
DATA_W, 16, instruction word width
ADDR_W, 9, instruction memory address width (matches pos[8:0])
MEM_DEPTH, 512, number of instruction words; maximum legal length

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERR
in_valid  input  1  host word valid
in_data  input  DATA_W  host word
in_ready  output  1  loader can accept in_data this cycle
mem_we  output  1  instruction memory write strobe
mem_addr  output  ADDR_W  write address
mem_wdata  output  DATA_W  write data
words_loaded  output  ADDR_W+1  payload words written so far
fin_file  output  1  load completed, checksum good
err  output  1  frame rejected

Behaviour:
- One clock; reset is synchronous and active-high. All outputs are registered.
- On rst: state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, words_loaded=0, fin_file=0, err=0, len=0, chk=0.
- A handshake occurs on any rising edge where in_valid=1 and in_ready=1.
- in_ready=1 only in HDR, LOAD and CHK. The host may hold in_valid low for any number of cycles with no effect.
- States:
  - IDLE: start -> HDR. Clear words_loaded, mem_addr, chk, fin_file and err.
  - HDR: on handshake, len=in_data.
    - If len==0 or len>MEM_DEPTH -> ERR.
    - Otherwise -> LOAD.
  - LOAD: on each handshake:
    - Next cycle: mem_we=1, mem_addr=words_loaded[ADDR_W-1:0], mem_wdata=in_data.
    - chk ^= in_data; words_loaded++.
    - When words_loaded reaches len -> CHK.
  - CHK: on handshake, in_data==chk -> DONE, otherwise -> ERR.
  - DONE: fin_file=1, held until start or rst. start -> HDR with all counters cleared.
  - ERR: err=1, held until start or rst. start -> HDR with all counters cleared.
- mem_we is a single-cycle pulse per payload word. It is never asserted in HDR or CHK, and never asserted for the header or trailer words.
- Write latency: handshake at edge N -> mem_we/mem_addr/mem_wdata valid in the cycle after edge N, sampled by memory at edge N+1. Back-to-back handshakes give back-to-back writes (1 word/cycle).
- mem_addr does not wrap. len is capped at MEM_DEPTH, so the last address written is MEM_DEPTH-1. words_loaded is ADDR_W+1 bits so it can hold MEM_DEPTH.
- start while in HDR, LOAD or CHK is ignored. The load continues.
- start and handshake in the same cycle in DONE/ERR: in_ready is 0, so no handshake occurs; the transition to HDR proceeds.
- rst mid-load: return to IDLE next edge, any pending mem_we is dropped. Memory contents are not cleared; previously written words remain.
- fin_file and err are never both 1.
- in_data bits above ADDR_W+1 in the header must be zero, otherwise the frame goes to ERR.

Test Plan:
1. Reset, start, send 3, 16'h1234, 16'hABCD, 16'h0F0F, 16'hB6F6 -> writes (0,1234),(1,ABCD),(2,0F0F) on 3 consecutive cycles; fin_file=1 after trailer; words_loaded=3; err=0.
2. Same frame with trailer 16'h0000 -> three writes occur, err=1, fin_file=0. Then start and resend the good frame -> fin_file=1, err=0.
3. Header 0, then separately header 16'd513 -> err=1 immediately after the header handshake; no mem_we pulses; in_ready=0 in ERR.
4. Length 4 with in_valid toggled 1,0,0,1,1,0,1 -> exactly 4 writes at addresses 0..3 in order, each one cycle after its handshake; correct fin_file.
5. Length 512 of incrementing data -> 512 writes, last at address 511 with mem_wdata=511; words_loaded=512; trailer = XOR of 0..511 = 16'h0000 -> fin_file=1.
6. Assert rst after 2 of 5 payload words -> IDLE next cycle, all outputs at reset values, no further mem_we. start during LOAD (separate run) -> ignored, load completes normally.

Source files
------------

// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : instr_mem_loader
//  Purpose  : Receives a framed program image (length header, payload words,
//             XOR checksum trailer) over valid/ready and writes the payload
//             sequentially into instruction memory starting at address 0.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_mem_loader #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 9,
  parameter int MEM_DEPTH = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W:0]   words_loaded,
  output logic              fin_file,
  output logic              err
);

  localparam logic [DATA_W-1:0] C_DEPTH = DATA_W'(MEM_DEPTH);
  localparam logic [ADDR_W:0]   C_ONE   = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_LOAD = 3'd2,
    S_CHK  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [ADDR_W:0]     wl_q, wl_d;
  logic                fin_q, fin_d;
  logic                err_q, err_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [DATA_W-1:0]   chk_q, chk_d;

  logic                w_hs;
  logic [ADDR_W:0]     w_wl_inc;

  // A word is consumed whenever the host offers one while we are ready
  assign w_hs     = in_valid & in_ready_q;
  assign w_wl_inc = wl_q + C_ONE;

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wl_q        <= '0;
      fin_q       <= 1'b0;
      err_q       <= 1'b0;
      len_q       <= '0;
      chk_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wl_q        <= wl_d;
      fin_q       <= fin_d;
      err_q       <= err_d;
      len_q       <= len_d;
      chk_q       <= chk_d;
    end
  end

  // Next-state logic; status outputs are derived from the next state so they
  // line up with the state register after the edge
  always_comb begin
    state_d     = state_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wl_d        = wl_q;
    len_d       = len_q;
    chk_d       = chk_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_HDR;
          wl_d       = '0;
          mem_addr_d = '0;
          chk_d      = '0;
          len_d      = '0;
        end
      end
      S_HDR: begin
        if (w_hs) begin
          len_d = in_data[ADDR_W:0];
          // Full-width compare also rejects any stray upper header bits
          if ((in_data == '0) || (in_data > C_DEPTH)) begin
            state_d = S_ERR;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (w_hs) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = wl_q[ADDR_W-1:0];
          mem_wdata_d = in_data;
          chk_d       = chk_q ^ in_data;
          wl_d        = w_wl_inc;
          if (w_wl_inc == len_q) begin
            state_d = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (w_hs) begin
          state_d = (in_data == chk_q) ? S_DONE : S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_HDR) || (state_d == S_LOAD) || (state_d == S_CHK);
    fin_d      = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
  end

  assign in_ready     = in_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign words_loaded = wl_q;
  assign fin_file     = fin_q;
  assign err          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_mem_loader
//  Purpose  : Self-checking bench for instr_mem_loader
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [9:0]  words_loaded;
  logic        fin_file;
  logic        err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [8:0]  last_addr;
  logic [15:0] last_data;

  typedef struct {
    int          edge_n;
    logic [8:0]  a;
    logic [15:0] d;
  } wr_t;
  wr_t expq[$];

  typedef struct packed {
    logic [15:0]      hdr;
    logic [2:0]       n;
    logic [3:0][15:0] w;
    logic [15:0]      trl;
    logic [3:0][1:0]  gaps;
    logic             fin;
    logic             err;
  } vec_t;
  vec_t vt[8];

  instr_mem_loader #(.DATA_W(16), .ADDR_W(9), .MEM_DEPTH(512)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .words_loaded(words_loaded), .fin_file(fin_file), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every write strobe must match the oldest outstanding payload handshake,
  // and appear in the cycle right after that handshake's edge
  always @(negedge clk) begin
    chk("fin_err_exclusive", {31'b0, fin_file & err}, 32'd0);
    if (mem_we) begin
      if (expq.size() == 0) begin
        chk("unexpected_we", {7'b0, mem_addr, mem_wdata}, 32'd0);
      end else begin
        wr_t e;
        e = expq.pop_front();
        chk("wr_addr", {23'b0, mem_addr}, {23'b0, e.a});
        chk("wr_data", {16'b0, mem_wdata}, {16'b0, e.d});
        chk("wr_latency", cyc, e.edge_n);
      end
      last_addr = mem_addr;
      last_data = mem_wdata;
    end
  end

  function automatic vec_t mk(input logic [15:0] h, input int n,
                              input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input logic [15:0] d,
                              input logic [15:0] trl, input logic [7:0] gaps,
                              input bit f, input bit e);
    vec_t v;
    v.hdr = h; v.n = 3'(n);
    v.w[0] = a; v.w[1] = b; v.w[2] = c; v.w[3] = d;
    v.trl = trl; v.gaps = gaps; v.fin = f; v.err = e;
    return v;
  endfunction

  // Offer one word and wait (bounded) for it to be accepted
  task automatic drive_word(input logic [15:0] d, input bit payload, input logic [8:0] a);
    int t;
    bit r;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    do begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!r && t < 50);
    in_valid = 1'b0;
    in_data  = 16'h0;
    if (!r) chk("handshake_timeout", 32'd0, 32'd1);
    else if (payload) expq.push_back('{cyc, a, d});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_vec(input int k, input vec_t v);
    pulse_start();
    drive_word(v.hdr, 1'b0, 9'd0);
    if (v.n != 0) begin
      for (int i = 0; i < int'(v.n); i++) begin
        idle(int'(v.gaps[i]));
        drive_word(v.w[i], 1'b1, 9'(i));
      end
      drive_word(v.trl, 1'b0, 9'd0);
    end
    @(negedge clk);
    chk($sformatf("v%0d_fin", k), {31'b0, fin_file}, {31'b0, v.fin});
    chk($sformatf("v%0d_err", k), {31'b0, err}, {31'b0, v.err});
    chk($sformatf("v%0d_words", k), {22'b0, words_loaded}, {29'b0, v.n});
    chk($sformatf("v%0d_ready", k), {31'b0, in_ready}, 32'd0);
    chk($sformatf("v%0d_pending", k), expq.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = mk(16'd3,   3, 16'h1234, 16'hABCD, 16'h0F0F, 16'h0, 16'hB6F6, 8'h00, 1, 0);
    vt[1] = mk(16'd3,   3, 16'h1234, 16'hABCD, 16'h0F0F, 16'h0, 16'h0000, 8'h00, 0, 1);
    vt[2] = mk(16'd3,   3, 16'h1234, 16'hABCD, 16'h0F0F, 16'h0, 16'hB6F6, 8'h00, 1, 0);
    vt[3] = mk(16'd0,   0, 16'h0,    16'h0,    16'h0,    16'h0, 16'h0,    8'h00, 0, 1);
    vt[4] = mk(16'd513, 0, 16'h0,    16'h0,    16'h0,    16'h0, 16'h0,    8'h00, 0, 1);
    vt[5] = mk(16'd4,   4, 16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h000F, 8'h48, 1, 0);
    vt[6] = mk(16'h8003,0, 16'h0,    16'h0,    16'h0,    16'h0, 16'h0,    8'h00, 0, 1);
    vt[7] = mk(16'd2,   2, 16'hAAAA, 16'h5555, 16'h0,    16'h0, 16'hFFFF, 8'h00, 1, 0);

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_we",    {31'b0, mem_we}, 32'd0);
    chk("rst_addr",  {23'b0, mem_addr}, 32'd0);
    chk("rst_wdata", {16'b0, mem_wdata}, 32'd0);
    chk("rst_words", {22'b0, words_loaded}, 32'd0);
    chk("rst_fin",   {31'b0, fin_file}, 32'd0);
    chk("rst_err",   {31'b0, err}, 32'd0);
    @(posedge clk);
    #1;

    for (int k = 0; k < 8; k++) run_vec(k, vt[k]);

    // start together with valid data while in DONE: no handshake, go to HDR
    start = 1'b1; in_valid = 1'b1; in_data = 16'd3;
    @(posedge clk);
    #1;
    start = 1'b0; in_valid = 1'b0; in_data = 16'h0;
    @(negedge clk);
    chk("restart_ready", {31'b0, in_ready}, 32'd1);
    chk("restart_fin",   {31'b0, fin_file}, 32'd0);
    chk("restart_words", {22'b0, words_loaded}, 32'd0);
    @(posedge clk);
    #1;
    run_vec(8, vt[0]);

    // Full-depth image of incrementing data; XOR of 0..511 is 0
    pulse_start();
    drive_word(16'd512, 1'b0, 9'd0);
    for (int i = 0; i < 512; i++) drive_word(16'(i), 1'b1, 9'(i));
    drive_word(16'h0000, 1'b0, 9'd0);
    @(negedge clk);
    chk("big_fin",   {31'b0, fin_file}, 32'd1);
    chk("big_err",   {31'b0, err}, 32'd0);
    chk("big_words", {22'b0, words_loaded}, 32'd512);
    chk("big_last_addr", {23'b0, last_addr}, 32'd511);
    chk("big_last_data", {16'b0, last_data}, 32'd511);
    @(posedge clk);
    #1;

    // start during LOAD must be ignored
    pulse_start();
    drive_word(16'd3, 1'b0, 9'd0);
    drive_word(16'h1111, 1'b1, 9'd0);
    start = 1'b1;
    drive_word(16'h2222, 1'b1, 9'd1);
    start = 1'b0;
    drive_word(16'h4444, 1'b1, 9'd2);
    drive_word(16'h7777, 1'b0, 9'd0);
    @(negedge clk);
    chk("ign_start_fin",   {31'b0, fin_file}, 32'd1);
    chk("ign_start_words", {22'b0, words_loaded}, 32'd3);
    @(posedge clk);
    #1;

    // Reset coinciding with the third payload handshake drops that write
    pulse_start();
    drive_word(16'd5, 1'b0, 9'd0);
    drive_word(16'hC001, 1'b1, 9'd0);
    drive_word(16'hC002, 1'b1, 9'd1);
    in_valid = 1'b1; in_data = 16'hC003; rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0; in_data = 16'h0;
    @(negedge clk);
    chk("mid_rst_ready", {31'b0, in_ready}, 32'd0);
    chk("mid_rst_we",    {31'b0, mem_we}, 32'd0);
    chk("mid_rst_addr",  {23'b0, mem_addr}, 32'd0);
    chk("mid_rst_wdata", {16'b0, mem_wdata}, 32'd0);
    chk("mid_rst_words", {22'b0, words_loaded}, 32'd0);
    chk("mid_rst_fin",   {31'b0, fin_file}, 32'd0);
    chk("mid_rst_err",   {31'b0, err}, 32'd0);
    idle(6);
    @(negedge clk);
    chk("mid_rst_idle_ready", {31'b0, in_ready}, 32'd0);
    chk("mid_rst_pending", expq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
